// File: rtl/db9_pkg.sv
// Shared definitions for the DB9 user-port joystick scanner: mode and FSM
// encodings, joystick bit positions and the active-low pin remap.
package db9_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_SINGLE = 2'd1,
        MODE_SPLIT  = 2'd2,
        MODE_SWAP   = 2'd3
    } db9_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL_A,
        ST_SAMP_A,
        ST_SEL_B,
        ST_SAMP_B,
        ST_DONE
    } db9_state_e;

    localparam int JOY_RIGHT = 0;
    localparam int JOY_LEFT  = 1;
    localparam int JOY_DOWN  = 2;
    localparam int JOY_UP    = 3;
    localparam int JOY_FIRE1 = 4;
    localparam int JOY_FIRE2 = 5;
    localparam int JOY_W     = 6;

    // User-port pins are active-low and wired in a different order to the joystick word.
    function automatic logic [JOY_W-1:0] db9_remap(input logic [7:0] user_in);
        logic [JOY_W-1:0] j;
        j[JOY_RIGHT] = ~user_in[3];
        j[JOY_LEFT]  = ~user_in[2];
        j[JOY_DOWN]  = ~user_in[1];
        j[JOY_UP]    = ~user_in[0];
        j[JOY_FIRE1] = ~user_in[4];
        j[JOY_FIRE2] = ~user_in[5];
        return j;
    endfunction

endpackage

// File: rtl/db9_debounce.sv
// Per-port sample debouncer: the filtered value follows the sample only after
// DEBOUNCE consecutive identical strobed samples.
module db9_debounce
    import db9_pkg::*;
#(
    parameter int unsigned DEBOUNCE = 3
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic             strobe_i,
    input  logic [JOY_W-1:0] sample_i,
    output logic [JOY_W-1:0] value_o
);

    localparam logic [2:0] CNT_MAX = 3'(DEBOUNCE);

    logic [2:0]       cnt_q,  cnt_d;
    logic [JOY_W-1:0] prev_q, prev_d;
    logic [JOY_W-1:0] filt_q, filt_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d  = cnt_q;
        prev_d = prev_q;
        filt_d = filt_q;
        if (strobe_i) begin
            if (sample_i == prev_q) begin
                if (cnt_q < CNT_MAX) cnt_d = cnt_q + 3'd1;
            end else begin
                cnt_d  = 3'd1;
                prev_d = sample_i;
            end
            if (cnt_d == CNT_MAX) filt_d = sample_i;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q  <= '0;
            prev_q <= '0;
            filt_q <= '0;
        end else if (clear_i) begin
            cnt_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            prev_q <= prev_d;
            filt_q <= filt_d;
        end
    end

    assign value_o = filt_q;

endmodule

// File: rtl/db9_joy_scanner.sv
// Scheduled DB9 joystick scanner: drives the splitter select, samples USER_IN
// after a settle delay, debounces each port and merges it into the HPS joystick words.
module db9_joy_scanner
    import db9_pkg::*;
#(
    parameter logic [15:0] SCAN_DIV = 16'd48000,
    parameter logic [7:0]  SETTLE   = 8'd96,
    parameter int unsigned DEBOUNCE = 3
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic [7:0]  USER_IN,
    output logic [1:0]  USER_OUT,
    input  logic [31:0] joy_hps_0,
    input  logic [31:0] joy_hps_1,
    output logic [31:0] joystick_0,
    output logic [31:0] joystick_1,
    output logic        frame_done
);

    db9_state_e       state_q;
    db9_mode_e        mode_q;
    logic [15:0]      div_q;
    logic [7:0]       cnt_q;
    logic             sel_q;
    logic             done_q;
    logic             div_tc;
    logic             settle_done;
    logic [JOY_W-1:0] pins;
    logic [JOY_W-1:0] filt_a, filt_b;
    logic [JOY_W-1:0] db_a_q, db_a_d, db_b_q, db_b_d;
    logic [31:0]      joy0_q, joy1_q;

    assign div_tc      = enable && (div_q == SCAN_DIV - 16'd1);
    // SEL states last max(SETTLE, 1) cycles.
    assign settle_done = ({1'b0, cnt_q} + 9'd1) >= {1'b0, SETTLE};
    assign pins        = db9_remap(USER_IN);

    always_ff @(posedge clk_sys) begin
        if (reset || !enable) div_q <= '0;
        else if (div_tc)      div_q <= '0;
        else                  div_q <= div_q + 16'd1;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_BYPASS;
            cnt_q   <= '0;
            sel_q   <= 1'b1;
            done_q  <= 1'b0;
        end else if (!enable) begin
            state_q <= ST_IDLE;
            mode_q  <= db9_mode_e'(mode);
            cnt_q   <= '0;
            sel_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // Mode tracks the input while idle and freezes for the duration of a frame.
                    mode_q <= db9_mode_e'(mode);
                    if (div_tc && db9_mode_e'(mode) != MODE_BYPASS) begin
                        state_q <= ST_SEL_A;
                        cnt_q   <= '0;
                        sel_q   <= (db9_mode_e'(mode) == MODE_SINGLE);
                    end
                end
                ST_SEL_A: begin
                    if (settle_done) state_q <= ST_SAMP_A;
                    else             cnt_q   <= cnt_q + 8'd1;
                end
                ST_SAMP_A: begin
                    if (mode_q == MODE_SINGLE) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ST_SEL_B;
                        cnt_q   <= '0;
                        sel_q   <= 1'b1;
                    end
                end
                ST_SEL_B: begin
                    if (settle_done) state_q <= ST_SAMP_B;
                    else             cnt_q   <= cnt_q + 8'd1;
                end
                ST_SAMP_B: begin
                    state_q <= ST_DONE;
                    done_q  <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    db9_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_a (
        .clk_i    (clk_sys),
        .reset_i  (reset),
        .clear_i  (!enable),
        .strobe_i (state_q == ST_SAMP_A),
        .sample_i (pins),
        .value_o  (filt_a)
    );

    db9_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_b (
        .clk_i    (clk_sys),
        .reset_i  (reset),
        .clear_i  (!enable),
        .strobe_i (state_q == ST_SAMP_B),
        .sample_i (pins),
        .value_o  (filt_b)
    );

    // DB9 contribution is snapshotted at frame end; HPS words still flow every cycle.
    always_comb begin
        db_a_d = db_a_q;
        db_b_d = db_b_q;
        if (mode_q == MODE_BYPASS) begin
            db_a_d = '0;
            db_b_d = '0;
        end else if (state_q == ST_DONE) begin
            case (mode_q)
                MODE_SINGLE: begin db_a_d = filt_a; db_b_d = '0;     end
                MODE_SPLIT:  begin db_a_d = filt_a; db_b_d = filt_b; end
                MODE_SWAP:   begin db_a_d = filt_b; db_b_d = filt_a; end
                default:     begin db_a_d = '0;     db_b_d = '0;     end
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            db_a_q <= '0;
            db_b_q <= '0;
            joy0_q <= '0;
            joy1_q <= '0;
        end else begin
            db_a_q <= db_a_d;
            db_b_q <= db_b_d;
            joy0_q <= joy_hps_0 | {26'b0, db_a_d};
            joy1_q <= joy_hps_1 | {26'b0, db_b_d};
        end
    end

    assign USER_OUT   = {1'b1, sel_q};
    assign joystick_0 = joy0_q;
    assign joystick_1 = joy1_q;
    assign frame_done = done_q;

endmodule

// File: doc/db9_joy_scanner.md
Name: db9_joy_scanner

Overview:
- Sequences the DB9 user-port joystick interface (single or two-port splitter) by driving the splitter select line and sampling USER_IN at fixed points in a scan frame.
- Debounces each sampled joystick and merges it with the HPS-side joystick words.
- Sits between hps_io outputs and core logic; replaces ad-hoc per-core USER_IN mapping with one scheduled, registered path.

Parameters:
- SCAN_DIV, 16'd48000, clk_sys cycles between scan-frame starts (1 kHz at 48 MHz).
- SETTLE, 8'd96, cycles between a select-line change and the sample that follows it.
- DEBOUNCE, 3, consecutive identical samples needed before the filtered value updates (1..7).

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous active-high reset
- enable  in  1  scanning enabled; 0 holds the FSM in IDLE
- mode  in  2  0 bypass, 1 single DB9, 2 splitter, 3 splitter with players swapped
- USER_IN  in  8  raw user-port pins, active-low; [3:0] up/down/left/right, [5:4] fire1/fire2, [7:6] unused
- USER_OUT  out  2  [0] splitter select (0 = port A, 1 = port B), [1] held 1 (released)
- joy_hps_0  in  32  HPS joystick, player 0
- joy_hps_1  in  32  HPS joystick, player 1
- joystick_0  out  32  merged player 0
- joystick_1  out  32  merged player 1
- frame_done  out  1  one-cycle pulse when a scan frame completes

Behaviour:
- Reset values: FSM IDLE, USER_OUT = 2'b11, joystick_0/1 = 0, frame_done = 0, divider = 0, debounce counters = 0, filtered values = 0.
- Pin remap (inverts active-low pins): pin6 = {~U[5], ~U[4], ~U[0], ~U[1], ~U[2], ~U[3]} gives bit0 right, 1 left, 2 down, 3 up, 4 fire1, 5 fire2.
- Divider counts 0..SCAN_DIV-1 while enable = 1. Terminal count starts a frame if FSM is IDLE; a terminal count seen while not IDLE is dropped. enable = 0 clears the divider.
- FSM states:
  - IDLE.
  - SEL_A: USER_OUT[0] = 0; wait SETTLE cycles.
  - SAMP_A: capture pin6 into sample A; 1 cycle.
  - SEL_B: USER_OUT[0] = 1; wait SETTLE cycles.
  - SAMP_B: capture into sample B; 1 cycle.
  - DONE: pulse frame_done; 1 cycle; go to IDLE.
- In mode 1, SAMP_A goes directly to DONE and USER_OUT[0] stays 1 for the whole frame.
- In mode 0, the FSM stays in IDLE.
- Mode is latched at frame start. A mode change mid-frame takes effect on the next frame.
- Debounce, per port, evaluated only in its SAMP state:
  - sample == previous sample: counter increments, saturating at DEBOUNCE.
  - sample != previous sample: counter resets to 1 and previous sample is updated.
  - When the counter reaches DEBOUNCE, the filtered value is loaded.
- Merge (registered, one cycle after DONE; held between frames):
  - mode 0: joystick_n = joy_hps_n; passes through every cycle with 1-cycle latency.
  - mode 1: joystick_0 = joy_hps_0 | {26'b0, filtA}; joystick_1 = joy_hps_1.
  - mode 2: joystick_0 = joy_hps_0 | filtA; joystick_1 = joy_hps_1 | filtB.
  - mode 3: as mode 2 with filtA and filtB exchanged.
  - HPS bits [31:6] always pass through unchanged.
  - In modes 1–3, HPS bit changes appear with 1-cycle latency, not only at frame end.
- Worst-case DB9 latency from pin change to output: DEBOUNCE frames + 2·SETTLE + 4 cycles.
- reset or enable falling mid-frame: abort to IDLE and set USER_OUT = 2'b11. On enable fall, filtered values are retained and debounce counters cleared; reset clears both.
- SETTLE = 0 is legal: the SEL state lasts 1 cycle.

Decomposition:
- Package db9_pkg holds:
  - mode encodings MODE_BYPASS/MODE_SINGLE/MODE_SPLIT/MODE_SWAP;
  - the FSM state enum;
  - joystick bit-index constants JOY_RIGHT..JOY_FIRE2.
- One sub-module, db9_debounce (6-bit value, saturating counter, sample strobe in), instantiated twice.

Test Plan:
- Reset with mode = 2, USER_IN = 8'h00 held: joystick_0/1 = 0 and USER_OUT = 2'b11 during reset, with no frame_done.
- Mode 1 with USER_IN = 8'hF7 (U3 low) for 3 frames: after the 3rd frame_done, joystick_0[0] = 1, and USER_OUT[0] never drops to 0.
- Mode 2 with USER_IN = 8'hEF while select = 0 and 8'hDF while select = 1: joystick_0 = 32'h10 and joystick_1 = 32'h20 after 3 frames. Mode 3 swaps these to 32'h20 and 32'h10.
- Glitch rejection: U4 low for one frame only → joystick_0[4] stays 0. Low for 3 frames → it sets.
- Mode 0 with joy_hps_0 = 32'h8000_0001: joystick_0 = 32'h8000_0001 one cycle later, and the FSM never leaves IDLE.
- Reset asserted in SEL_B: the next cycle gives IDLE, USER_OUT = 2'b11 and outputs 0. After release, the first frame starts only after a full SCAN_DIV count.
